// File: rtl/pixel_delay_line.sv
// Runtime-programmable multi-channel pixel delay line with stall and valid.
// Circular RAM of MAX_DEPTH words; delay change or flush restarts the fill count.
module pixel_delay_line #(
   parameter  int DATA_W        = 8,
   parameter  int CHANNELS      = 1,
   parameter  int MAX_DEPTH     = 16,
   parameter  int DEFAULT_DELAY = 1,
   localparam int W             = DATA_W * CHANNELS,
   localparam int DSEL_W        = $clog2(MAX_DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              en,
   input  logic              flush,
   input  logic [DSEL_W-1:0] delay_sel,
   input  logic [W-1:0]      in_data,
   output logic [W-1:0]      out_data,
   output logic              out_valid
);

   localparam int AW = $clog2(MAX_DEPTH);
   localparam logic [DSEL_W-1:0] MAX_D  = DSEL_W'(MAX_DEPTH);
   localparam logic [DSEL_W-1:0] DEF_D  = DSEL_W'(DEFAULT_DELAY);
   localparam logic [DSEL_W-1:0] ONE    = DSEL_W'(1);
   localparam logic [AW-1:0]     P_ONE  = AW'(1);

   logic [W-1:0]      mem [MAX_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DSEL_W-1:0] cur_delay;
   logic [DSEL_W-1:0] eff;
   logic [DSEL_W-1:0] fill;
   logic [DSEL_W-1:0] fill_sat;
   logic [DSEL_W:0]   fill_inc;
   logic              chg;
   logic              dly1;
   logic              ok_valid;
   logic [W-1:0]      rd_word;

   always_comb begin
      eff = delay_sel;
      unique case (1'b1)
         (delay_sel == '0):   eff = ONE;
         (delay_sel > MAX_D): eff = MAX_D;
         default:             eff = delay_sel;
      endcase
   end

   // Read slot holds the word written D-1 enabled edges ago.
   assign rd_ptr   = wr_ptr - AW'(eff - ONE);
   assign chg      = (eff != cur_delay);
   assign dly1     = (eff == ONE);
   assign fill_inc = {1'b0, fill} + {1'b0, ONE};
   assign fill_sat = (fill == MAX_D) ? fill : fill + ONE;
   assign ok_valid = (fill_inc >= {1'b0, eff});
   assign rd_word  = dly1 ? in_data : mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (en && !flush) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         wr_ptr    <= '0;
         fill      <= '0;
         cur_delay <= DEF_D;
      end else begin
         cur_delay <= eff;
         if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            fill      <= '0;
         end else if (chg) begin
            fill <= en ? ONE : '0;
            if (en) begin
               out_data  <= rd_word;
               out_valid <= dly1;
               wr_ptr    <= wr_ptr + P_ONE;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (en) begin
            out_data  <= rd_word;
            out_valid <= ok_valid;
            fill      <= fill_sat;
            wr_ptr    <= wr_ptr + P_ONE;
         end
      end
   end

endmodule
